// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle for dac_spi_tx. The generator side uses master and the
// transmitter uses slave.
interface dac_spi_tx_if;
  logic [7:0] dat;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_done;
  logic       sclk;
  logic       mosi;
  logic       cs_n;

  modport master (
    output dat, valid,
    input  ready, busy, frame_done, sclk, mosi, cs_n
  );

  modport slave (
    input  dat, valid,
    output ready, busy, frame_done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/dac_spi_tx.sv
// 16-bit SPI mode-0 transmitter for an 8-bit serial DAC with a one-entry latest-wins holding
// register. Optional DAC_SPI_TX_CHANGE_ONLY_EN suppresses frames that repeat the last sample sent.
module dac_spi_tx #(
  parameter int unsigned CLKDIV = 4,
  parameter logic [3:0]  CMD    = 4'b0000
) (
  input logic          clk,
  input logic          rst_n,
  dac_spi_tx_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StHold, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  held_q, held_d;
  logic        pending_q, pending_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        frame_done_q, frame_done_d;
  logic        div_done;
  logic        start;
`ifdef DAC_SPI_TX_CHANGE_ONLY_EN
  logic [7:0]  last_q, last_d;
`endif

  assign div_done = (div_q == DivLast);

`ifdef DAC_SPI_TX_CHANGE_ONLY_EN
  assign start = (state_q == StIdle) && pending_q && (held_q != last_q);
`else
  assign start = (state_q == StIdle) && pending_q;
`endif

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    held_d       = held_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
`ifdef DAC_SPI_TX_CHANGE_ONLY_EN
    last_d       = last_q;
    if (start) last_d = held_q;
`endif

    if (bus.valid) begin
      held_d    = bus.dat;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        // A strobe arriving while the held sample is consumed stays pending.
        if (pending_q) pending_d = bus.valid;
        if (start) begin
          shift_d = {CMD, held_q, 4'b0000};
          bit_d   = 4'd15;
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        div_d = div_q + 8'd1;
        if (div_done) begin
          div_d   = '0;
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        div_d = div_q + 8'd1;
        if (div_done) begin
          div_d = '0;
          if (bit_q != 4'd0) begin
            bit_d   = bit_q - 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
            state_d = StShiftLo;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        div_d = div_q + 8'd1;
        if (div_done) begin
          div_d        = '0;
          frame_done_d = 1'b1;
          state_d      = StGap;
        end
      end
      StGap: begin
        div_d = div_q + 8'd1;
        if (div_done) begin
          div_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin outputs are registered copies of the next state so they never glitch.
    sclk_d = (state_d == StShiftHi);
    cs_n_d = !((state_d == StShiftLo) || (state_d == StShiftHi) || (state_d == StHold));
    mosi_d = cs_n_d ? 1'b0 : shift_d[15];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      held_q       <= '0;
      pending_q    <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef DAC_SPI_TX_CHANGE_ONLY_EN
      last_q       <= 8'h80;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      held_q       <= held_d;
      pending_q    <= pending_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
`ifdef DAC_SPI_TX_CHANGE_ONLY_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.ready      = !pending_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = frame_done_q;
  assign bus.sclk       = sclk_q;
  assign bus.mosi       = mosi_q;
  assign bus.cs_n       = cs_n_q;

endmodule
